// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM states, funct3 codes and access-decoding helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    return (f3 == F3_B || f3 == F3_H || f3 == F3_W) || (!store && (f3 == F3_BU || f3 == F3_HU));
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    return f3[1:0] == 2'b00 ? 4'b0001 << lo : f3[1:0] == 2'b01 ? 4'b0011 << lo : 4'b1111;
  endfunction
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    return f3[1:0] == 2'b00 ? {4{wd[7:0]}} : f3[1:0] == 2'b01 ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/lsu_format.sv
// lsu_format: selects the addressed lane of a read word and sign/zero-extends it
module lsu_format
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    read_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit bridging the core to a req/gnt + rvalid data bus, stalling until done
module lsu
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    Funct3,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          Stall,
  output logic          AccessFault,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_err
);
  lsu_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d, err_q, err_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [DW-1:0] fmt;
  logic          req, legal;
  assign req   = MemRead | MemWrite;
  assign legal = f3_legal(Funct3, MemWrite) && !misaligned(Funct3, Addr[1:0]);
  lsu_format u_format (
    .rdata    (bus_rdata),
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .read_data(fmt)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req && legal) begin
        state_d = REQ;
        addr_d  = Addr;
        be_d    = byte_en(Funct3, Addr[1:0]);
        we_d    = MemWrite;
        wdata_d = MemWrite ? store_data(Funct3, WriteData) : '0;
        f3_d    = Funct3;
      end
      REQ: state_d = bus_gnt ? WAIT : REQ;
      WAIT: if (bus_rvalid) begin
        state_d = DONE;
        err_d   = bus_err;
        rdata_d = (we_q || bus_err) ? '0 : fmt;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // Bus fields are only driven while the request is outstanding.
  assign bus_req     = state_q == REQ;
  assign bus_we      = bus_req & we_q;
  assign bus_addr    = bus_req ? {addr_q[AW-1:2], 2'b00} : '0;
  assign bus_be      = bus_req ? be_q : '0;
  assign bus_wdata   = bus_req ? wdata_q : '0;
  assign ReadData    = rdata_q;
  assign Stall       = (state_q == IDLE && req && legal) || state_q == REQ || state_q == WAIT;
  assign AccessFault = (state_q == IDLE && req && !legal) || (state_q == DONE && err_q);
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven accesses against a bus responder, with a scoreboard of expected load results
module tb_lsu;
  logic        clk = 0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, AccessFault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  typedef struct {
    logic        mr, mw;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          gdly, rdly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_rd;
    logic        e_flt;
  } vec_t;
  typedef struct {
    logic [31:0] rd;
    logic        flt;
    int          stalls;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .AccessFault(AccessFault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {31'b0, bus_req}, 0);
    chk({tag, "_we"}, {31'b0, bus_we}, 0);
    chk({tag, "_be"}, {28'b0, bus_be}, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_rdata"}, ReadData, 0);
    chk({tag, "_stall"}, {31'b0, Stall}, 0);
    chk({tag, "_fault"}, {31'b0, AccessFault}, 0);
  endtask

  task automatic run_access(input vec_t v);
    bit   granted, resp, fin;
    int   gw, rw, stalls;
    exp_t e;
    granted = 0; resp = 0; fin = 0; gw = 0; rw = 0; stalls = 0;
    @(posedge clk); #1;
    MemRead = v.mr; MemWrite = v.mw; Funct3 = v.f3; Addr = v.addr; WriteData = v.wd;
    exp_q.push_back('{rd: v.e_rd, flt: v.e_flt, stalls: 3 + v.gdly + v.rdly});
    for (int c = 0; c < 40 && !fin; c++) begin
      if (resp) begin
        bus_rvalid = 0; bus_err = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("done_stall", {31'b0, Stall}, 0);
        chk("done_readdata", ReadData, e.rd);
        chk("done_fault", {31'b0, AccessFault}, {31'b0, e.flt});
        chk("stall_cycles", stalls, e.stalls);
        fin = 1;
      end else begin
        if (granted) begin
          bus_gnt = 0;
          bus_rvalid = (rw == v.rdly);
          resp = bus_rvalid;
          bus_rdata = resp ? v.rdata : $urandom;
          bus_err = resp && v.err;
          rw++;
        end else if (bus_req) begin
          bus_gnt = (gw == v.gdly);
          granted = bus_gnt;
          bus_rvalid = !bus_gnt;  // stray response during REQ must be ignored
          bus_rdata = 32'h5A5A5A5A;
          bus_err = !bus_gnt;
          gw++;
        end
        @(negedge clk);
        if (Stall) stalls++;
        if (bus_req) begin
          chk("bus_addr", bus_addr, v.e_addr);
          chk("bus_be", {28'b0, bus_be}, {28'b0, v.e_be});
          chk("bus_we", {31'b0, bus_we}, {31'b0, v.e_we});
          chk("bus_wdata", bus_wdata, v.e_wdata);
        end
        @(posedge clk); #1;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL access_timeout: got no completion, expected completion within 40 cycles");
      void'(exp_q.pop_front());
    end
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0;
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk("hold_readdata", ReadData, v.e_rd);
    chk("hold_fault", {31'b0, AccessFault}, 0);
    chk("idle_req", {31'b0, bus_req}, 0);
  endtask

  task automatic run_fault(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    MemRead = mr; MemWrite = mw; Funct3 = f3; Addr = a; WriteData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("flt_fault", {31'b0, AccessFault}, 1);
    chk("flt_stall", {31'b0, Stall}, 0);
    chk("flt_req", {31'b0, bus_req}, 0);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk("flt_pulse_end", {31'b0, AccessFault}, 0);
    chk("flt_req_after", {31'b0, bus_req}, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h100, 4'b1111, 0, 32'h0, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 0};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 32'h100, 4'b1000, 0, 32'h0, 32'h00000080, 0};
    vecs[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 0, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h0, 0};
    vecs[4]  = '{1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 5, 0, 0, 32'h40, 4'b1111, 0, 32'h0, 32'h0BADF00D, 0};
    vecs[5]  = '{1, 0, 3'b010, 32'h44, 32'h0, 32'h12345678, 1, 2, 1, 32'h44, 4'b1111, 0, 32'h0, 32'h0, 1};
    vecs[6]  = '{1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 1, 0, 32'h100, 4'b1100, 0, 32'h0, 32'hFFFF8001, 0};
    vecs[7]  = '{1, 0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 2, 0, 0, 32'h100, 4'b0011, 0, 32'h0, 32'h0000F234, 0};
    vecs[8]  = '{0, 1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 0, 0, 0, 32'h300, 4'b0010, 1, 32'hA5A5A5A5, 32'h0, 0};
    vecs[9]  = '{0, 1, 3'b010, 32'h404, 32'hCAFEBABE, 32'h0, 1, 1, 0, 32'h404, 4'b1111, 1, 32'hCAFEBABE, 32'h0, 0};
    vecs[10] = '{1, 1, 3'b010, 32'h10, 32'h11223344, 32'hFFFFFFFF, 0, 0, 0, 32'h10, 4'b1111, 1, 32'h11223344, 32'h0, 0};
    vecs[11] = '{1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 0, 32'h100, 4'b0010, 0, 32'h0, 32'h0000007F, 0};
    reset = 0; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WriteData = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #1;
    reset = 1;
    foreach (vecs[i]) run_access(vecs[i]);
    run_fault(1, 0, 3'b010, 32'h102);
    run_fault(1, 0, 3'b011, 32'h100);
    run_fault(0, 1, 3'b001, 32'h201);
    run_fault(1, 0, 3'b001, 32'h103);
    run_fault(0, 1, 3'b100, 32'h100);
    run_fault(1, 0, 3'b111, 32'h100);
    // Reset while waiting for the response, then a stray rvalid in IDLE.
    @(posedge clk); #1;
    MemRead = 1; Funct3 = 3'b010; Addr = 32'h100;
    @(posedge clk); #1;
    chk("mid_req", {31'b0, bus_req}, 1);
    bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    chk("mid_wait_stall", {31'b0, Stall}, 1);
    reset = 0; MemRead = 0;
    #1;
    chk_all_zero("mid_rst");
    @(posedge clk); #1;
    reset = 1;
    bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_stall", {31'b0, Stall}, 0);
    chk("stray_req", {31'b0, bus_req}, 0);
    @(posedge clk); #1;
    bus_rvalid = 0;
    @(negedge clk);
    chk("stray_readdata", ReadData, 0);
    chk("stray_fault", {31'b0, AccessFault}, 0);
    run_access('{1, 0, 3'b010, 32'h100, 32'h0, 32'h13579BDF, 0, 0, 0, 32'h100, 4'b1111, 0, 32'h0, 32'h13579BDF, 0});
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
